// File: rtl/apb_cmd_queue.sv
// CPU-side command FIFO feeding an APB master, one request issued at a time.
// Latency: push->MTRANSFER 2 edges; MDONE edge -> rsp_valid pulse in the following cycle.
// Backpressure: cmd_ready drops when DEPTH entries are held; a pop in the same cycle does not free room early.
module apb_cmd_queue #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int PROT_SIZE = 3,
    parameter int STRB_SIZE = DATA_SIZE / 8,
    parameter int DEPTH     = 4
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [PROT_SIZE-1:0]     cmd_prot,
    input  logic [ADDR_SIZE-1:0]     cmd_addr,
    input  logic [DATA_SIZE-1:0]     cmd_wdata,
    input  logic [STRB_SIZE-1:0]     cmd_strb,
    output logic                     MTRANSFER,
    output logic                     MWRITE,
    output logic [PROT_SIZE-1:0]     MPROT,
    output logic [ADDR_SIZE-1:0]     MADDR,
    output logic [DATA_SIZE-1:0]     MWDATA,
    output logic [STRB_SIZE-1:0]     MSTRB,
    input  logic                     MDONE,
    input  logic [DATA_SIZE-1:0]     MRDATA,
    input  logic                     MSLVERR,
    output logic                     rsp_valid,
    output logic                     rsp_write,
    output logic [DATA_SIZE-1:0]     rsp_rdata,
    output logic                     rsp_slverr,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic                 write;
        logic [PROT_SIZE-1:0] prot;
        logic [ADDR_SIZE-1:0] addr;
        logic [DATA_SIZE-1:0] wdata;
        logic [STRB_SIZE-1:0] strb;
    } entry_t;

    typedef enum logic {IDLE, BUSY} state_t;

    entry_t               mem_q [DEPTH];
    entry_t               entry_in;
    entry_t               head;
    state_t               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [7:0]           err_count_q, err_count_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_write_q, rsp_write_d;
    logic [DATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_slverr_q, rsp_slverr_d;
    logic                 push, pop;

    assign entry_in  = {cmd_write, cmd_prot, cmd_addr, cmd_wdata, cmd_strb};
    assign head      = mem_q[rd_ptr_q];
    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == BUSY) && MDONE;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_count_d  = err_count_q;
        rsp_valid_d  = pop;
        rsp_write_d  = rsp_write_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE:    if (count_q != '0) state_d = BUSY;
            BUSY:    if (MDONE) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rsp_write_d  = head.write;
            rsp_rdata_d  = head.write ? '0 : MRDATA;
            rsp_slverr_d = MSLVERR;
            if (MSLVERR && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
        end
    end

    // Head fields are only exposed while issuing; the master sees zeros otherwise.
    always_comb begin
        MTRANSFER = 1'b0;
        MWRITE    = 1'b0;
        MPROT     = '0;
        MADDR     = '0;
        MWDATA    = '0;
        MSTRB     = '0;
        if (state_q == BUSY) begin
            MTRANSFER = 1'b1;
            MWRITE    = head.write;
            MPROT     = head.prot;
            MADDR     = head.addr;
            MWDATA    = head.wdata;
            MSTRB     = head.strb;
        end
    end

    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= entry_in;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_count_q  <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_write_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_count_q  <= err_count_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_write_q  <= rsp_write_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_write  = rsp_write_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign err_count  = err_count_q;
    assign level      = count_q;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// Bench for apb_cmd_queue: directed scenarios plus a randomized run against a queue-based model.
module tb_apb_cmd_queue;

    localparam int DEPTH = 4;

    logic        PCLK, PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_prot;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        MTRANSFER, MWRITE;
    logic [2:0]  MPROT;
    logic [31:0] MADDR, MWDATA;
    logic [3:0]  MSTRB;
    logic        MDONE;
    logic [31:0] MRDATA;
    logic        MSLVERR;
    logic        rsp_valid, rsp_write, rsp_slverr;
    logic [31:0] rsp_rdata;
    logic [7:0]  err_count;
    logic [2:0]  level;

    apb_cmd_queue #(.DEPTH(DEPTH)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_prot(cmd_prot), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .MTRANSFER(MTRANSFER), .MWRITE(MWRITE), .MPROT(MPROT), .MADDR(MADDR),
        .MWDATA(MWDATA), .MSTRB(MSTRB), .MDONE(MDONE), .MRDATA(MRDATA), .MSLVERR(MSLVERR),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .err_count(err_count), .level(level)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    typedef struct {
        logic        w;
        logic [2:0]  prot;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } ent_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    ent_t        mq[$];
    bit          m_busy;
    bit          m_rsp_valid, m_rsp_write, m_rsp_slverr;
    logic [31:0] m_rsp_rdata;
    int          m_err;
    logic [31:0] got_addr[$];

    task automatic model_reset();
        mq.delete();
        m_busy = 0; m_rsp_valid = 0; m_rsp_write = 0; m_rsp_slverr = 0;
        m_rsp_rdata = '0; m_err = 0;
    endtask

    // Advance one clock edge, updating the model from the inputs seen at that edge.
    task automatic tick();
        bit   push_m, pop_m, busy_n;
        ent_t e;
        if (!PRESETn) begin
            @(posedge PCLK); #1;
            model_reset();
            return;
        end
        e.w = cmd_write; e.prot = cmd_prot; e.addr = cmd_addr; e.wdata = cmd_wdata; e.strb = cmd_strb;
        push_m = cmd_valid && (mq.size() != DEPTH);
        pop_m  = m_busy && MDONE;
        busy_n = m_busy ? !MDONE : (mq.size() != 0);
        m_rsp_valid = pop_m;
        if (pop_m) begin
            m_rsp_write  = mq[0].w;
            m_rsp_rdata  = mq[0].w ? 32'h0 : MRDATA;
            m_rsp_slverr = MSLVERR;
            if (MSLVERR && m_err < 255) m_err++;
        end
        @(posedge PCLK); #1;
        if (pop_m) void'(mq.pop_front());
        if (push_m) mq.push_back(e);
        m_busy = busy_n;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_prot = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
        MDONE = 0; MRDATA = 0; MSLVERR = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        PRESETn = 0;
        tick(); tick();
        PRESETn = 1;
        model_reset();
    endtask

    task automatic set_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
    endtask

    task automatic wait_xfer(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (MTRANSFER) begin ok = 1; return; end
            tick();
        end
    endtask

    // Push one command into an empty queue and complete it with the given master response.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] rd,
                           input logic err, output bit ok);
        set_cmd(w, a, 32'hA5A5_0000 ^ a, 4'hF, 3'b001);
        tick();
        cmd_valid = 0;
        wait_xfer(ok);
        if (!ok) return;
        MRDATA = rd; MSLVERR = err; MDONE = 1;
        tick();
        MDONE = 0; MSLVERR = 0; MRDATA = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({MTRANSFER, MWRITE, MPROT, MADDR, MWDATA, MSTRB} !== '0) begin
            n_fail++; $display("FAIL reset_mout: got %h want 0", {MTRANSFER, MWRITE, MPROT, MADDR, MWDATA, MSTRB});
        end
        n_checks++;
        if ({rsp_valid, rsp_write, rsp_rdata, rsp_slverr, err_count, level} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_write, rsp_rdata, rsp_slverr, err_count, level});
        end
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        MDONE = 1; MSLVERR = 1; MRDATA = 32'hFFFF_FFFF;
        tick();
        idle_inputs();
        n_checks++;
        if (rsp_valid !== 1'b0 || err_count !== 8'd0) begin
            n_fail++; $display("FAIL idle_mdone: got rsp_valid=%b err=%0d want 0/0", rsp_valid, err_count);
        end
    endtask

    task automatic test_single_write();
        set_cmd(1'b1, 32'd2, 32'h0123_4567, 4'hF, 3'b011);
        tick();
        cmd_valid = 0;
        n_checks++;
        if (level !== 3'd1 || MTRANSFER !== 1'b0) begin
            n_fail++; $display("FAIL sw_push: got level=%0d mtr=%b want 1/0", level, MTRANSFER);
        end
        tick();
        n_checks++;
        if ({MTRANSFER, MWRITE, MPROT, MADDR, MWDATA, MSTRB} !== {1'b1, 1'b1, 3'b011, 32'd2, 32'h0123_4567, 4'hF}) begin
            n_fail++; $display("FAIL sw_issue: got mtr=%b addr=%h wdata=%h", MTRANSFER, MADDR, MWDATA);
        end
        tick();
        MDONE = 1;
        n_checks++;
        if (MADDR !== 32'd2 || MTRANSFER !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL sw_hold: got addr=%h mtr=%b rsp=%b want 2/1/0", MADDR, MTRANSFER, rsp_valid);
        end
        tick();
        MDONE = 0;
        n_checks++;
        if ({rsp_valid, rsp_write, rsp_slverr, MTRANSFER, level} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0}) begin
            n_fail++; $display("FAIL sw_rsp: got v=%b w=%b e=%b mtr=%b lvl=%0d want 1/1/0/0/0",
                               rsp_valid, rsp_write, rsp_slverr, MTRANSFER, level);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL sw_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_fill_backpressure();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            set_cmd(1'b1, 32'(2 + i), $urandom, 4'hF, 3'b000);
            tick();
        end
        n_checks++;
        if (cmd_ready !== 1'b0 || level !== 3'd4) begin
            n_fail++; $display("FAIL fill_full: got ready=%b level=%0d want 0/4", cmd_ready, level);
        end
        set_cmd(1'b1, 32'd6, 32'h0, 4'hF, 3'b000);
        tick();
        cmd_valid = 0;
        n_checks++;
        if (level !== 3'd4) begin n_fail++; $display("FAIL fill_refuse: got level=%0d want 4", level); end
        got_addr.delete();
        got_addr.push_back(MADDR);
        MDONE = 1;
        tick();
        MDONE = 0;
        n_checks++;
        if (cmd_ready !== 1'b1 || level !== 3'd3) begin
            n_fail++; $display("FAIL fill_pop: got ready=%b level=%0d want 1/3", cmd_ready, level);
        end
        for (int i = 0; i < 40 && (level != 0 || MTRANSFER); i++) begin
            MDONE = MTRANSFER;
            if (MTRANSFER) got_addr.push_back(MADDR);
            tick();
        end
        MDONE = 0;
        n_checks++;
        if (got_addr.size() != 4) begin
            n_fail++; $display("FAIL fill_count: got %0d issues want 4", got_addr.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_addr[i] !== 32'(2 + i)) begin
                    n_fail++; $display("FAIL fill_order[%0d]: got %0d want %0d", i, got_addr[i], 2 + i);
                end
            end
        end
    endtask

    task automatic test_read_data();
        bit ok;
        run_cmd(1'b0, 32'd5, 32'h7825_4500, 1'b0, ok);
        n_checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_rdata !== 32'h7825_4500) begin
            n_fail++; $display("FAIL rd_data: got ok=%b v=%b w=%b rdata=%h want 1/1/0/78254500",
                               ok, rsp_valid, rsp_write, rsp_rdata);
        end
        run_cmd(1'b1, 32'd9, 32'hDEAD_BEEF, 1'b0, ok);
        n_checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL wr_rdata: got ok=%b v=%b w=%b rdata=%h want 1/1/1/0",
                               ok, rsp_valid, rsp_write, rsp_rdata);
        end
    endtask

    task automatic test_slave_error();
        bit ok;
        apply_reset();
        run_cmd(1'b1, 32'd35, 32'h0, 1'b1, ok);
        n_checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_slverr !== 1'b1) begin
            n_fail++; $display("FAIL err_wr: got ok=%b v=%b err=%b want 1/1/1", ok, rsp_valid, rsp_slverr);
        end
        run_cmd(1'b0, 32'd60, 32'h1234, 1'b1, ok);
        n_checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_slverr !== 1'b1 || err_count !== 8'd2) begin
            n_fail++; $display("FAIL err_rd: got ok=%b v=%b err=%b cnt=%0d want 1/1/1/2",
                               ok, rsp_valid, rsp_slverr, err_count);
        end
    endtask

    task automatic test_err_saturate();
        bit ok;
        bit all_ok = 1;
        for (int i = 0; i < 258; i++) begin
            run_cmd(1'b0, 32'(i), 32'(i), 1'b1, ok);
            all_ok &= ok;
        end
        n_checks++;
        if (!all_ok || err_count !== 8'd255) begin
            n_fail++; $display("FAIL err_sat: got ok=%b cnt=%0d want 1/255", all_ok, err_count);
        end
    endtask

    task automatic test_wait_states();
        bit ok;
        logic [71:0] snap;
        apply_reset();
        set_cmd(1'b1, 32'h40, 32'hCAFE_F00D, 4'h5, 3'b110);
        tick();
        cmd_valid = 0;
        wait_xfer(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ws_issue: got no MTRANSFER want 1"); end
        snap = {MWRITE, MPROT, MADDR, MWDATA, MSTRB};
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if ({MWRITE, MPROT, MADDR, MWDATA, MSTRB} !== snap || MTRANSFER !== 1'b1 || rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL ws_stable[%0d]: got %h mtr=%b rsp=%b want %h/1/0",
                                   i, {MWRITE, MPROT, MADDR, MWDATA, MSTRB}, MTRANSFER, rsp_valid, snap);
            end
        end
        MDONE = 1;
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ws_early: got %b want 0", rsp_valid); end
        tick();
        MDONE = 0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_write !== 1'b1) begin
            n_fail++; $display("FAIL ws_rsp: got v=%b w=%b want 1/1", rsp_valid, rsp_write);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b0, 32'(16 + i), 32'h0, 4'h0, 3'b000);
            tick();
        end
        cmd_valid = 0;
        n_checks++;
        if (MTRANSFER !== 1'b1 || level !== 3'd3) begin
            n_fail++; $display("FAIL rm_pre: got mtr=%b level=%0d want 1/3", MTRANSFER, level);
        end
        #3 PRESETn = 0;
        #1;
        n_checks++;
        if (MTRANSFER !== 1'b0 || level !== 3'd0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rm_async: got mtr=%b level=%0d ready=%b want 0/0/1", MTRANSFER, level, cmd_ready);
        end
        MDONE = 1;
        tick();
        PRESETn = 1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (rsp_valid !== 1'b0 || MTRANSFER !== 1'b0) begin
                n_fail++; $display("FAIL rm_quiet[%0d]: got rsp=%b mtr=%b want 0/0", i, rsp_valid, MTRANSFER);
            end
        end
        MDONE = 0;
        run_cmd(1'b0, 32'h77, 32'h0000_0055, 1'b0, ok);
        n_checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== 32'h55) begin
            n_fail++; $display("FAIL rm_fresh: got ok=%b v=%b rdata=%h want 1/1/55", ok, rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_random();
        logic [72:0] exp_m;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            exp_m = '0;
            if (m_busy && mq.size() != 0)
                exp_m = {1'b1, mq[0].w, mq[0].prot, mq[0].addr, mq[0].wdata, mq[0].strb};
            n_checks++;
            if ({MTRANSFER, MWRITE, MPROT, MADDR, MWDATA, MSTRB} !== exp_m) begin
                n_fail++; $display("FAIL rnd_m[%0d]: got %h want %h", c, {MTRANSFER, MWRITE, MPROT, MADDR, MWDATA, MSTRB}, exp_m);
            end
            n_checks++;
            if (cmd_ready !== (mq.size() != DEPTH) || level !== 3'(mq.size()) || err_count !== 8'(m_err)) begin
                n_fail++; $display("FAIL rnd_ctl[%0d]: got ready=%b level=%0d err=%0d want %b/%0d/%0d",
                                   c, cmd_ready, level, err_count, mq.size() != DEPTH, mq.size(), m_err);
            end
            n_checks++;
            if (rsp_valid !== m_rsp_valid ||
                (m_rsp_valid && {rsp_write, rsp_rdata, rsp_slverr} !== {m_rsp_write, m_rsp_rdata, m_rsp_slverr})) begin
                n_fail++; $display("FAIL rnd_rsp[%0d]: got v=%b w=%b d=%h e=%b want %b/%b/%h/%b", c, rsp_valid,
                                   rsp_write, rsp_rdata, rsp_slverr, m_rsp_valid, m_rsp_write, m_rsp_rdata, m_rsp_slverr);
            end
            cmd_valid = ($urandom_range(0, 99) < 55);
            cmd_write = $urandom_range(0, 1);
            cmd_prot  = 3'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            cmd_strb  = 4'($urandom);
            MDONE     = ($urandom_range(0, 99) < 35);
            MRDATA    = $urandom;
            MSLVERR   = ($urandom_range(0, 99) < 30);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        PRESETn = 1;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_write();
        test_fill_backpressure();
        test_read_data();
        test_slave_error();
        test_err_saturate();
        test_wait_states();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_cmd_queue.md
# apb_cmd_queue

CPU-side command queue placed directly upstream of the APB master. It accepts read/write requests from the CPU over a valid/ready handshake and buffers them in a small FIFO. It presents one request at a time to the APB master's M* request inputs and holds each stable until the master reports completion. It then returns read data and slave-error status to the CPU as a one-cycle response pulse.

## Interface
Parameters:
- ADDR_SIZE, 32, address width
- DATA_SIZE, 32, data width
- PROT_SIZE, 3, protection attribute width
- STRB_SIZE, DATA_SIZE/8, byte-strobe width
- DEPTH, 4, queue entries (power of 2, ≥2)

Ports:
- PCLK  in  1  clock. One clock domain. Reset is asynchronous and active-low.
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  CPU request present
- cmd_ready  out  1  queue can accept (not full)
- cmd_write  in  1  1 = write, 0 = read
- cmd_prot  in  PROT_SIZE  protection attributes
- cmd_addr  in  ADDR_SIZE  target address
- cmd_wdata  in  DATA_SIZE  write data
- cmd_strb  in  STRB_SIZE  write strobes
- MTRANSFER  out  1  request to APB master; high while an entry is being issued
- MWRITE, MPROT, MADDR, MWDATA, MSTRB  out  as cmd_*  head-entry fields driven to the master
- MDONE  in  1  master completion strobe (ACCESS phase with PREADY=1), one cycle
- MRDATA  in  DATA_SIZE  read data from master, valid with MDONE
- MSLVERR  in  1  slave error from master, valid with MDONE
- rsp_valid  out  1  one-cycle response pulse
- rsp_write  out  1  direction of the completed command
- rsp_rdata  out  DATA_SIZE  read data (0 for writes)
- rsp_slverr  out  1  error flag of the completed command
- err_count  out  8  saturating count of completions with MSLVERR=1
- level  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry circular FIFO holding {write, prot, addr, wdata, strb}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately, 0..DEPTH.
- Push: cmd_valid && cmd_ready at a rising edge. cmd_ready = (count != DEPTH), combinational from registered count. When full, a push is refused even if a pop occurs in the same cycle.
- Pop: occurs at the edge where state=BUSY && MDONE=1.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Issue FSM, two states:
  - IDLE: MTRANSFER=0. If count≠0, go to BUSY.
  - BUSY: MTRANSFER=1. M* outputs driven from the head entry and held stable. When MDONE=1: pop, register the response, go to IDLE.
- MDONE seen in IDLE is ignored. No pop and no response.
- M* outputs in IDLE: all zero.
- Response capture: rsp_write=head.write, rsp_rdata = head.write ? 0 : MRDATA, rsp_slverr=MSLVERR.
- err_count: increments on MDONE&&MSLVERR in BUSY and saturates at 255.
- level = count.

## Timing
- Reset (asynchronous, PRESETn=0): FSM=IDLE, pointers=0, count=0, MTRANSFER=0, all M* outputs=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_slverr=0, err_count=0. cmd_ready=1 after reset.
- Reset asserted mid-transfer: all queued entries are discarded and no response is produced.
- Push-to-issue latency: push at edge N into an empty queue in IDLE → count=1 after N → BUSY and MTRANSFER=1 after edge N+1.
- Completion: MDONE=1 sampled at edge M → rsp_valid=1 for exactly cycle M..M+1. MTRANSFER=0 during that cycle.
- Back-to-back issue: the next entry is issued at edge M+1. Each transfer therefore has at least one MTRANSFER-low cycle before it.
- Minimum per-command throughput is 1 command per (master latency + 1) cycles.
- cmd_ready reflects count after the previous edge. A pop at edge M frees a slot visible from cycle M onward.

## Test plan
- Single write: push write addr=2, wdata=0x01234567, strb=0xF, prot=3'b011. Master asserts MDONE 2 cycles after MTRANSFER rises, with MSLVERR=0. Required: MADDR=2 held through MDONE; rsp_valid pulse with rsp_write=1, rsp_slverr=0; level returns to 0.
- Fill and backpressure: push 5 commands with MDONE held low. Required: cmd_ready=0 after 4 pushes, level=4, 5th push not accepted. Assert MDONE → one pop, cmd_ready=1; issue order is addresses 2, 3, 4, 5.
- Read data return: push read addr=5, MDONE with MRDATA=0x78254500. Required: rsp_rdata=0x78254500, rsp_write=0. A write response shows rsp_rdata=0.
- Slave error: push write addr=35 and read addr=60, each completing with MSLVERR=1. Required: rsp_slverr=1 on both responses, err_count=2.
- Wait states: MDONE held low for 8 cycles during BUSY. Required: M* outputs stable all 8 cycles, no rsp_valid. The response arrives after the cycle in which MDONE rises.
- Reset mid-operation: 3 entries queued, PRESETn driven low asynchronously while BUSY. Required: MTRANSFER=0 and level=0 immediately; no rsp_valid after release; a fresh push issues normally.
